// File: rtl/student_id_checker.sv
// Sequence recognizer for a stream of BCD digits: tracks how far the programmed
// ID has been received in order, pulses match on completion and counts matches.
module student_id_checker #(
    parameter int                  ID_LEN = 8,
    parameter logic [4*ID_LEN-1:0] ID_SEQ = 32'h4107_2153
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_valid,
    input  logic [3:0] din,
    input  logic       clr_cnt,
    output logic       match,
    output logic       bad_digit,
    output logic [3:0] progress,
    output logic [7:0] match_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        MATCHING = 1'b1
    } state_e;

    localparam logic [3:0] LAST_IDX  = 4'(ID_LEN - 1);
    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [7:0] CNT_MAX   = 8'hFF;

    // progress_q is the recognizer state; state_q mirrors it as IDLE/MATCHING.
    state_e     state_q, state_d;
    logic [3:0] progress_q, progress_d;
    logic       match_q, match_d;
    logic       bad_digit_q, bad_digit_d;
    logic [7:0] match_cnt_q, match_cnt_d;

    logic [3:0] id_digit [16];
    logic [3:0] exp_digit;

    // Unpack ID_SEQ into an index-addressable table, first digit at index 0.
    for (genvar g = 0; g < 16; g++) begin : g_digit
        if (g < ID_LEN) begin : g_used
            assign id_digit[g] = ID_SEQ[4*(ID_LEN-1-g) +: 4];
        end else begin : g_unused
            assign id_digit[g] = 4'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        progress_d  = progress_q;
        match_d     = 1'b0;
        bad_digit_d = 1'b0;
        match_cnt_d = match_cnt_q;
        exp_digit   = (state_q == IDLE) ? id_digit[0] : id_digit[progress_q];

        if (din_valid) begin
            if (din > BCD_MAX) begin
                bad_digit_d = 1'b1;
                progress_d  = 4'd0;
            end else if (din == exp_digit) begin
                if (progress_q == LAST_IDX) begin
                    match_d    = 1'b1;
                    progress_d = 4'd0;
                end else begin
                    progress_d = progress_q + 4'd1;
                end
            end else begin
                // Only the first ID digit can restart a sequence; no deeper overlap.
                progress_d = (din == id_digit[0]) ? 4'd1 : 4'd0;
            end
        end

        state_d = (progress_d == 4'd0) ? IDLE : MATCHING;

        // Clear wins over a simultaneous increment; the match pulse still fires.
        if (clr_cnt) begin
            match_cnt_d = 8'd0;
        end else if (match_d && (match_cnt_q != CNT_MAX)) begin
            match_cnt_d = match_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            progress_q  <= 4'd0;
            match_q     <= 1'b0;
            bad_digit_q <= 1'b0;
            match_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            progress_q  <= progress_d;
            match_q     <= match_d;
            bad_digit_q <= bad_digit_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign match     = match_q;
    assign bad_digit = bad_digit_q;
    assign progress  = progress_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_student_id_checker.sv
// Directed bench for student_id_checker: hand-computed expectations checked with
// immediate assertions one cycle after each digit is sampled.
module tb_student_id_checker;

    logic       clk;
    logic       reset;
    logic       din_valid;
    logic [3:0] din;
    logic       clr_cnt;
    logic       match;
    logic       bad_digit;
    logic [3:0] progress;
    logic [7:0] match_cnt;

    int n_cmp;
    int n_err;

    logic [3:0] id_tab [8];

    student_id_checker dut (
        .clk       (clk),
        .reset     (reset),
        .din_valid (din_valid),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .match     (match),
        .bad_digit (bad_digit),
        .progress  (progress),
        .match_cnt (match_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are checked 1 unit after the rising edge.
    task automatic step(input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        din_valid = v;
        din       = d;
        clr_cnt   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] exp_prog,
                             input logic exp_match, input logic exp_bad);
        check({tag, "_progress"}, {4'd0, progress}, {4'd0, exp_prog});
        check({tag, "_match"}, {7'd0, match}, {7'd0, exp_match});
        check({tag, "_bad"}, {7'd0, bad_digit}, {7'd0, exp_bad});
    endtask

    task automatic send_id(input string tag, input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, id_tab[i], (i == 7) ? clr_last : 1'b0);
            check_out(tag, (i == 7) ? 4'd0 : 4'(i + 1), (i == 7), 1'b0);
        end
    endtask

    initial begin
        int pulses;
        n_cmp = 0;
        n_err = 0;
        id_tab = '{4'd4, 4'd1, 4'd0, 4'd7, 4'd2, 4'd1, 4'd5, 4'd3};
        reset     = 1'b0;
        din_valid = 1'b0;
        din       = 4'd0;
        clr_cnt   = 1'b0;

        // Reset state
        #12;
        check_out("reset", 4'd0, 1'b0, 1'b0);
        check("reset_cnt", match_cnt, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        // Plain sequence 4,1,0,7,2,1,5,3
        send_id("seq1", 1'b0);
        check("seq1_cnt", match_cnt, 8'd1);
        step(1'b0, 4'd0, 1'b0);
        check_out("seq1_idle", 4'd0, 1'b0, 1'b0);

        // Restart on first digit: 4,1,4,1,0,7,2,1,5,3
        step(1'b0, 4'd0, 1'b1);
        check("clr1_cnt", match_cnt, 8'd0);
        step(1'b1, 4'd4, 1'b0); check_out("rst_a", 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd1, 1'b0); check_out("rst_b", 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0); check_out("rst_c", 4'd1, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, id_tab[i], 1'b0);
            check_out("rst_tail", (i == 7) ? 4'd0 : 4'(i + 1), (i == 7), 1'b0);
        end
        check("rst_cnt", match_cnt, 8'd1);

        // Mismatch on a non-first digit drops to 0
        step(1'b1, 4'd4, 1'b0); check_out("mis_a", 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd9, 1'b0); check_out("mis_b", 4'd0, 1'b0, 1'b0);

        // Non-BCD digit: 4,1,0,12
        step(1'b1, 4'd4, 1'b0);  check_out("bad_a", 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd1, 1'b0);  check_out("bad_b", 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd0, 1'b0);  check_out("bad_c", 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd12, 1'b0); check_out("bad_d", 4'd0, 1'b0, 1'b1);
        step(1'b0, 4'd12, 1'b0); check_out("bad_e", 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0);  check_out("bad_f", 4'd1, 1'b0, 1'b0);
        step(1'b0, 4'd15, 1'b0); check_out("bad_g", 4'd1, 1'b0, 1'b0);
        check("bad_cnt", match_cnt, 8'd1);
        step(1'b1, 4'd9, 1'b0);  check_out("bad_h", 4'd0, 1'b0, 1'b0);

        // 256 back-to-back sequences: pulse every 8 cycles, count saturates at 255
        step(1'b0, 4'd0, 1'b1);
        check("clr2_cnt", match_cnt, 8'd0);
        pulses = 0;
        for (int s = 0; s < 256; s++) begin
            for (int i = 0; i < 8; i++) begin
                step(1'b1, id_tab[i], 1'b0);
                if (match) pulses++;
                check("b2b_match", {7'd0, match}, {7'd0, (i == 7)});
            end
            check("b2b_cnt", match_cnt, (s < 255) ? 8'(s + 1) : 8'd255);
        end
        check("b2b_pulses", 8'(pulses == 256), 8'd1);
        check("sat_cnt", match_cnt, 8'd255);

        // clr_cnt on the final digit: match still pulses, count clears
        send_id("clrlast", 1'b1);
        check("clrlast_cnt", match_cnt, 8'd0);
        step(1'b0, 4'd0, 1'b0);
        check_out("clrlast_idle", 4'd0, 1'b0, 1'b0);
        check("clrlast_cnt2", match_cnt, 8'd0);

        // Mid-sequence reset discards partial progress
        send_id("pre", 1'b0);
        check("pre_cnt", match_cnt, 8'd1);
        for (int i = 0; i < 4; i++) step(1'b1, id_tab[i], 1'b0);
        check("mid_prog", {4'd0, progress}, 8'd4);
        din_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check_out("async_rst", 4'd0, 1'b0, 1'b0);
        check("async_cnt", match_cnt, 8'd0);
        #3;
        reset = 1'b1;
        for (int i = 4; i < 8; i++) begin
            step(1'b1, id_tab[i], 1'b0);
            check_out("post_rst", 4'd0, 1'b0, 1'b0);
        end
        send_id("after", 1'b0);
        check("after_cnt", match_cnt, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
